alu_op_sequencer: RTL and testbench

- Upstream sequencer for the 4-bit load-register ALU (ports ldA, ldB, din, control, out, cout, Zero, Overflow).
- Accepts a complete operation (A, B, opcode) over a valid/ready request handshake.
- Serialises the operands onto the ALU's shared din bus with ldA, then ldB, and drives control.
- Captures the ALU result and flags into registers and returns them over a valid/ready response handshake.

---
 rtl/alu_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// ----------------
// Upstream sequencer for a 4-bit load-register ALU. It accepts one complete
// operation (a, b, opcode) over a valid/ready request handshake. It then loads
// operand A and operand B over the ALU's shared din bus, using ldA and then
// ldB. It holds control steady while the ALU settles, captures the result and
// flags, and returns them over a valid/ready response handshake. Only one
// operation is in flight at a time.
//
// Ports:
//   clk, rst_n               clock; synchronous active-low reset
//   req_valid/req_ready      request handshake; req_a, req_b, req_op payload
//   ldA, ldB, din, control   ALU load strobes, shared operand bus, opcode
//   alu_out/cout/zero/ovf    ALU result and flags
//   rsp_valid/rsp_ready      response handshake; rsp_result/cout/zero/ovf payload
//   busy                     high whenever the sequencer is not idle
//   op_count                 completed responses, wraps

module alu_op_sequencer #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1,  // legal range 1..15
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [2:0]           req_op,
    output logic                 ldA,
    output logic                 ldB,
    output logic [WIDTH-1:0]     din,
    output logic [2:0]           control,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_cout,
    input  logic                 alu_zero,
    input  logic                 alu_ovf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_cout,
    output logic                 rsp_zero,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StExec,
        StResp
    } state_e;

    localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      din_q, din_d;
    logic [2:0]            ctl_q, ctl_d;
    logic [3:0]            settle_q, settle_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic                  cout_q, cout_d;
    logic                  zero_q, zero_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            b_q      <= '0;
            din_q    <= '0;
            ctl_q    <= '0;
            settle_q <= '0;
            res_q    <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            din_q    <= din_d;
            ctl_q    <= ctl_d;
            settle_q <= settle_d;
            res_q    <= res_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        din_d    = din_q;
        ctl_d    = ctl_q;
        settle_d = settle_q;
        res_d    = res_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                // Operand A goes straight onto the bus register so it is
                // already presented during the ldA cycle; B waits in b_q.
                if (req_valid) begin
                    din_d   = req_a;
                    b_d     = req_b;
                    ctl_d   = req_op;
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                din_d   = b_q;
                state_d = StLoadB;
            end
            StLoadB: begin
                settle_d = SettleInit;
                state_d  = StExec;
            end
            StExec: begin
                if (settle_q == 4'd0) begin
                    res_d   = alu_out;
                    cout_d  = alu_cout;
                    zero_d  = alu_zero;
                    ovf_d   = alu_ovf;
                    state_d = StResp;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and strobe outputs are pure state decodes.
    assign req_ready  = (state_q == StIdle);
    assign ldA        = (state_q == StLoadA);
    assign ldB        = (state_q == StLoadB);
    assign rsp_valid  = (state_q == StResp);
    assign busy       = (state_q != StIdle);

    assign din        = din_q;
    assign control    = ctl_q;
    assign rsp_result = res_q;
    assign rsp_cout   = cout_q;
    assign rsp_zero   = zero_q;
    assign rsp_ovf    = ovf_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. Three instances: default build (0),
// SETTLE_CYCLES=3 (1) and CNT_WIDTH=2 (2). Each instance drives its own
// behavioural load-register ALU. Expected responses are computed directly
// from the requested operands and opcode.

module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [2:0] req_op;
    logic       req_valid_v [3];
    logic       rsp_ready_v [3];
    logic       ovr_en      [3];
    logic [3:0] ovr_val;

    logic       req_ready_w [3];
    logic       ldA_w       [3];
    logic       ldB_w       [3];
    logic [3:0] din_w       [3];
    logic [2:0] ctl_w       [3];
    logic [3:0] alu_out_w   [3];
    logic       alu_cout_w  [3];
    logic       alu_zero_w  [3];
    logic       alu_ovf_w   [3];
    logic       rv_w        [3];
    logic [3:0] res_w       [3];
    logic       co_w        [3];
    logic       zr_w        [3];
    logic       ov_w        [3];
    logic       busy_w      [3];
    logic [7:0] cnt_w       [3];
    logic [7:0] op_count0, op_count1;
    logic [1:0] op_count2;

    int total = 0;
    int bad   = 0;
    int exp_cnt [3];
    int cmod    [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 shl a, 7 pass b.
    // Returns {ovf, zero, cout, result}.
    function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [4:0] s;
        logic       v;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[3] == b[3]) && (s[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                v = (a[3] != b[3]) && (s[3] != a[3]);
            end
            3'd2:    s = {1'b0, a & b};
            3'd3:    s = {1'b0, a | b};
            3'd4:    s = {1'b0, a ^ b};
            3'd5:    s = {1'b0, ~a};
            3'd6:    s = {a, 1'b0};
            default: s = {1'b0, b};
        endcase
        return {v, s[3:0] == 4'd0, s[4], s[3:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_alu
        logic [3:0] ra = '0;
        logic [3:0] rb = '0;
        logic [6:0] r;
        always @(posedge clk) begin
            if (ldA_w[g]) ra <= din_w[g];
            if (ldB_w[g]) rb <= din_w[g];
        end
        assign r             = alu_f(ra, rb, ctl_w[g]);
        assign alu_out_w[g]  = ovr_en[g] ? ovr_val : r[3:0];
        assign alu_cout_w[g] = r[4];
        assign alu_zero_w[g] = r[5];
        assign alu_ovf_w[g]  = r[6];
    end

    assign cnt_w[0] = op_count0;
    assign cnt_w[1] = op_count1;
    assign cnt_w[2] = {6'b0, op_count2};

    alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_WIDTH(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_v[0]), .req_ready(req_ready_w[0]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .ldA(ldA_w[0]), .ldB(ldB_w[0]),
        .din(din_w[0]), .control(ctl_w[0]), .alu_out(alu_out_w[0]),
        .alu_cout(alu_cout_w[0]), .alu_zero(alu_zero_w[0]), .alu_ovf(alu_ovf_w[0]),
        .rsp_valid(rv_w[0]), .rsp_ready(rsp_ready_v[0]), .rsp_result(res_w[0]),
        .rsp_cout(co_w[0]), .rsp_zero(zr_w[0]), .rsp_ovf(ov_w[0]), .busy(busy_w[0]),
        .op_count(op_count0)
    );

    alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(3), .CNT_WIDTH(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_v[1]), .req_ready(req_ready_w[1]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .ldA(ldA_w[1]), .ldB(ldB_w[1]),
        .din(din_w[1]), .control(ctl_w[1]), .alu_out(alu_out_w[1]),
        .alu_cout(alu_cout_w[1]), .alu_zero(alu_zero_w[1]), .alu_ovf(alu_ovf_w[1]),
        .rsp_valid(rv_w[1]), .rsp_ready(rsp_ready_v[1]), .rsp_result(res_w[1]),
        .rsp_cout(co_w[1]), .rsp_zero(zr_w[1]), .rsp_ovf(ov_w[1]), .busy(busy_w[1]),
        .op_count(op_count1)
    );

    alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_v[2]), .req_ready(req_ready_w[2]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .ldA(ldA_w[2]), .ldB(ldB_w[2]),
        .din(din_w[2]), .control(ctl_w[2]), .alu_out(alu_out_w[2]),
        .alu_cout(alu_cout_w[2]), .alu_zero(alu_zero_w[2]), .alu_ovf(alu_ovf_w[2]),
        .rsp_valid(rv_w[2]), .rsp_ready(rsp_ready_v[2]), .rsp_result(res_w[2]),
        .rsp_cout(co_w[2]), .rsp_zero(zr_w[2]), .rsp_ovf(ov_w[2]), .busy(busy_w[2]),
        .op_count(op_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {req_ready, ldA, ldB, din, control, rsp_valid, result, cout, zero, ovf, busy, count}
    function automatic logic [26:0] snap(input int k);
        return {req_ready_w[k], ldA_w[k], ldB_w[k], din_w[k], ctl_w[k], rv_w[k], res_w[k],
                co_w[k], zr_w[k], ov_w[k], busy_w[k], cnt_w[k]};
    endfunction

    // One full transaction on instance k. hold = cycles rsp_ready stays low after
    // rsp_valid; glitch moves alu_out during EXEC; keep/na/nb/nop set the request
    // lines right after the accept edge.
    task automatic run_op(input int k, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input int hold, input bit glitch,
                          input bit keep, input logic [3:0] na, input logic [3:0] nb,
                          input logic [2:0] nop, input string tag);
        int         settle;
        int         n;
        logic [6:0] e;
        logic [6:0] got;
        settle = (k == 1) ? 3 : 1;
        e = alu_f(a, b, op);
        if (glitch) e[3:0] = 4'h6;
        req_a = a; req_b = b; req_op = op; req_valid_v[k] = 1'b1;
        n = 0;
        while (req_ready_w[k] !== 1'b1 && n < 20) begin step(); n++; end
        total++;
        if (n >= 20) begin
            bad++; $display("FAIL %s accept: req_ready never rose (got %b, want 1)", tag,
                            req_ready_w[k]);
        end
        step();
        req_valid_v[k] = keep; req_a = na; req_b = nb; req_op = nop;
        total++;
        if ({ldA_w[k], ldB_w[k], din_w[k], ctl_w[k], busy_w[k], req_ready_w[k], rv_w[k]}
            !== {1'b1, 1'b0, a, op, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL %s load_a: got %b %b %h %h %b %b %b want 1 0 %h %h 1 0 0",
                            tag, ldA_w[k], ldB_w[k], din_w[k], ctl_w[k], busy_w[k],
                            req_ready_w[k], rv_w[k], a, op);
        end
        step();
        total++;
        if ({ldA_w[k], ldB_w[k], din_w[k], ctl_w[k], busy_w[k], req_ready_w[k], rv_w[k]}
            !== {1'b0, 1'b1, b, op, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL %s load_b: got %b %b %h %h %b %b %b want 0 1 %h %h 1 0 0",
                            tag, ldA_w[k], ldB_w[k], din_w[k], ctl_w[k], busy_w[k],
                            req_ready_w[k], rv_w[k], b, op);
        end
        for (int i = 0; i < settle; i++) begin
            step();
            if (glitch && i == 1) begin ovr_en[k] = 1'b1; ovr_val = 4'h9; end
            if (glitch && i == 2) ovr_val = 4'h6;
            total++;
            if ({ldA_w[k], ldB_w[k], din_w[k], ctl_w[k], busy_w[k], req_ready_w[k], rv_w[k]}
                !== {1'b0, 1'b0, b, op, 1'b1, 1'b0, 1'b0}) begin
                bad++; $display("FAIL %s exec%0d: got %b %b %h %h %b %b %b want 0 0 %h %h 1 0 0",
                                tag, i, ldA_w[k], ldB_w[k], din_w[k], ctl_w[k], busy_w[k],
                                req_ready_w[k], rv_w[k], b, op);
            end
        end
        step();
        ovr_en[k] = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) step();
            got = {ov_w[k], zr_w[k], co_w[k], res_w[k]};
            total++;
            if ({rv_w[k], req_ready_w[k], busy_w[k], ldA_w[k], ldB_w[k], ctl_w[k], got}
                !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, op, e}) begin
                bad++; $display("FAIL %s resp%0d: got v=%b rdy=%b busy=%b ld=%b%b ctl=%h ovzc_res=%b want v=1 rdy=0 busy=1 ld=00 ctl=%h ovzc_res=%b",
                                tag, i, rv_w[k], req_ready_w[k], busy_w[k], ldA_w[k], ldB_w[k],
                                ctl_w[k], got, op, e);
            end
        end
        rsp_ready_v[k] = 1'b1;
        step();
        rsp_ready_v[k] = 1'b0;
        exp_cnt[k] = (exp_cnt[k] + 1) % cmod[k];
        total++;
        if ({rv_w[k], busy_w[k], req_ready_w[k], cnt_w[k]} !== {1'b0, 1'b0, 1'b1, 8'(exp_cnt[k])})
        begin
            bad++; $display("FAIL %s done: got v=%b busy=%b rdy=%b cnt=%0d want v=0 busy=0 rdy=1 cnt=%0d",
                            tag, rv_w[k], busy_w[k], req_ready_w[k], cnt_w[k], exp_cnt[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (snap(k) !== {1'b1, 26'b0}) begin
                bad++; $display("FAIL reset%0d: got %b want %b", k, snap(k), {1'b1, 26'b0});
            end
            exp_cnt[k] = 0;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(0, 4'b0101, 4'b0011, 3'b000, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'h0, "basic_add");
    endtask

    task automatic test_hold();
        run_op(0, 4'(
$urandom), 4'($urandom), 3'($urandom), 5, 1'b0, 1'b0, 4'h0, 4'h0, 3'h0, "hold");
    endtask

    task automatic test_back_to_back();
        run_op(0, 4'hf, 4'hf, 3'b000, 0, 1'b0, 1'b1, 4'h0, 4'h0, 3'h0, "b2b_first");
        run_op(0, 4'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 4'($urandom), 4'($urandom),
               3'($urandom), "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op(0, 4'($urandom), 4'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                   1'b0, 1'b0, 4'($urandom), 4'($urandom), 3'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid();
        req_a = 4'ha; req_b = 4'h3; req_op = 3'd1; req_valid_v[0] = 1'b1;
        step();  // accept edge
        req_valid_v[0] = 1'b0;
        step();  // LOAD_B
        step();  // EXEC
        rst_n = 1'b0;
        step();
        total++;
        if (snap(0) !== {1'b1, 26'b0}) begin
            bad++; $display("FAIL reset_mid: got %b want %b", snap(0), {1'b1, 26'b0});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({rv_w[0], req_ready_w[0], busy_w[0], cnt_w[0]} !== {1'b0, 1'b1, 1'b0, 8'd0})
            begin
                bad++; $display("FAIL reset_mid_after%0d: got v=%b rdy=%b busy=%b cnt=%0d want 0 1 0 0",
                                i, rv_w[0], req_ready_w[0], busy_w[0], cnt_w[0]);
            end
        end
    endtask

    task automatic test_settle();
        run_op(1, 4'($urandom), 4'($urandom), 3'($urandom), 2, 1'b1, 1'b0, 4'h0, 4'h0, 3'h0,
               "settle_glitch");
        for (int i = 0; i < 3; i++) begin
            run_op(1, 4'($urandom), 4'($urandom), 3'($urandom), int'($urandom_range(0, 2)),
                   1'b0, 1'b0, 4'h0, 4'h0, 3'h0, "settle_random");
        end
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 5; i++) begin
            run_op(2, 4'($urandom), 4'($urandom), 3'($urandom), 0, 1'b0, 1'b0, 4'h0, 4'h0,
                   3'h0, "count_wrap");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_a = '0; req_b = '0; req_op = '0; ovr_val = '0;
        for (int k = 0; k < 3; k++) begin
            req_valid_v[k] = 1'b0;
            rsp_ready_v[k] = 1'b0;
            ovr_en[k]      = 1'b0;
            exp_cnt[k]     = 0;
        end
        cmod[0] = 256; cmod[1] = 256; cmod[2] = 4;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_settle();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
